lpif_tx_arbiter: RTL and testbench

LPIF_TX_ARBITER -- requirements
Module: lpif_tx_arbiter

---
 rtl/lpif_pkg.sv | 24 ++
 rtl/lpif_tx_outreg.sv | 74 +++++++
 rtl/lpif_tx_arbiter.sv | 160 ++++++++++++++++
 tb/tb_lpif_tx_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lpif_pkg.sv
// Shared LPIF TX definitions: LTSSM status encoding, arbiter FSM states and default widths.
package lpif_pkg;

    localparam int unsigned LPIF_BYTES  = 64;
    localparam int unsigned LPIF_DATA_W = 8 * LPIF_BYTES;

    typedef enum logic [3:0] {
        RESET     = 4'h0,
        ACTIVE    = 4'h1,
        L1        = 4'h4,
        L2        = 4'h8,
        LINKRESET = 4'h9,
        LINKERROR = 4'hA,
        RETRAIN   = 4'hB,
        DISABLED  = 4'hC
    } ltssm_sts_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DLP_PKT = 2'd1,
        TLP_PKT = 2'd2
    } arb_state_e;

endpackage

// File: rtl/lpif_tx_outreg.sv
// Single-entry LPIF TX output register: holds a beat until pl_trdy, routes DLP/TLP markers.
module lpif_tx_outreg
    import lpif_pkg::*;
#(
    parameter int unsigned BYTES  = LPIF_BYTES,
    parameter int unsigned DATA_W = LPIF_DATA_W
) (
    input  logic              lclk,
    input  logic              lpreset_n,
    input  logic              i_flush,
    input  logic              i_load,
    input  logic              i_is_tlp,
    input  logic [DATA_W-1:0] i_data,
    input  logic [BYTES-1:0]  i_valid,
    input  logic [BYTES-1:0]  i_start,
    input  logic [BYTES-1:0]  i_end,
    input  logic              i_trdy,
    output logic              o_irdy,
    output logic [DATA_W-1:0] o_data,
    output logic [BYTES-1:0]  o_valid,
    output logic [BYTES-1:0]  o_dlpstart,
    output logic [BYTES-1:0]  o_dlpend,
    output logic [BYTES-1:0]  o_tlpstart,
    output logic [BYTES-1:0]  o_tlpend
);

    logic              r_irdy;
    logic [DATA_W-1:0] r_data;
    logic [BYTES-1:0]  r_valid;
    logic [BYTES-1:0]  r_dlpstart;
    logic [BYTES-1:0]  r_dlpend;
    logic [BYTES-1:0]  r_tlpstart;
    logic [BYTES-1:0]  r_tlpend;

    // Loads are only issued when the register is empty or being drained this cycle.
    always_ff @(posedge lclk or negedge lpreset_n) begin
        if (!lpreset_n) begin
            r_irdy     <= 1'b0;
            r_data     <= '0;
            r_valid    <= '0;
            r_dlpstart <= '0;
            r_dlpend   <= '0;
            r_tlpstart <= '0;
            r_tlpend   <= '0;
        end else if (i_flush) begin
            r_irdy     <= 1'b0;
            r_data     <= '0;
            r_valid    <= '0;
            r_dlpstart <= '0;
            r_dlpend   <= '0;
            r_tlpstart <= '0;
            r_tlpend   <= '0;
        end else if (i_load) begin
            r_irdy     <= 1'b1;
            r_data     <= i_data;
            r_valid    <= i_valid;
            r_dlpstart <= i_is_tlp ? '0 : i_start;
            r_dlpend   <= i_is_tlp ? '0 : i_end;
            r_tlpstart <= i_is_tlp ? i_start : '0;
            r_tlpend   <= i_is_tlp ? i_end : '0;
        end else if (r_irdy && i_trdy) begin
            r_irdy     <= 1'b0;
        end
    end

    assign o_irdy     = r_irdy;
    assign o_data     = r_data;
    assign o_valid    = r_valid;
    assign o_dlpstart = r_dlpstart;
    assign o_dlpend   = r_dlpend;
    assign o_tlpstart = r_tlpstart;
    assign o_tlpend   = r_tlpend;

endmodule

// File: rtl/lpif_tx_arbiter.sv
// LPIF TX arbiter: packet-atomic DLP/TLP arbitration onto one LPIF transmit port.
// Define LPIF_ARB_STARVE_EN to add the TLP anti-starvation counter; otherwise DLP has strict priority.
module lpif_tx_arbiter
    import lpif_pkg::*;
#(
    parameter int unsigned BYTES      = LPIF_BYTES,
    parameter int unsigned DATA_W     = 8 * BYTES,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              lclk,
    input  logic              lpreset_n,
    input  logic [3:0]        pl_state_sts,
    input  logic              pl_linkUp,
    input  logic              dlp_vld,
    output logic              dlp_rdy,
    input  logic [DATA_W-1:0] dlp_data,
    input  logic [BYTES-1:0]  dlp_valid,
    input  logic [BYTES-1:0]  dlp_start,
    input  logic [BYTES-1:0]  dlp_end,
    input  logic              tlp_vld,
    output logic              tlp_rdy,
    input  logic [DATA_W-1:0] tlp_data,
    input  logic [BYTES-1:0]  tlp_valid,
    input  logic [BYTES-1:0]  tlp_start,
    input  logic [BYTES-1:0]  tlp_end,
    output logic              lp_irdy,
    output logic [DATA_W-1:0] lp_data,
    output logic [BYTES-1:0]  lp_valid,
    output logic [BYTES-1:0]  lp_dlpstart,
    output logic [BYTES-1:0]  lp_dlpend,
    output logic [BYTES-1:0]  lp_tlpstart,
    output logic [BYTES-1:0]  lp_tlpend,
    input  logic              pl_trdy,
    output logic              tx_abort
);

    arb_state_e r_state;
    arb_state_e w_nxt_state;
    logic       r_link_act;
    logic       r_tx_abort;
    logic       w_link_act;
    logic       w_can_acc;
    logic       w_starve_hit;
    logic       w_tlp_win;
    logic       w_dlp_rdy;
    logic       w_tlp_rdy;
    logic       w_abort_nxt;
    logic       w_dlp_xfer;
    logic       w_tlp_xfer;
    logic       w_dlp_final;
    logic       w_tlp_final;

    assign w_link_act  = pl_linkUp && (pl_state_sts == 4'(ACTIVE));
    // r_link_act also keeps both rdy outputs low throughout reset.
    assign w_can_acc   = w_link_act && r_link_act && (!lp_irdy || pl_trdy);
    assign w_dlp_final = |dlp_end;
    assign w_tlp_final = |tlp_end;
    assign w_tlp_win   = tlp_vld && (!dlp_vld || w_starve_hit);
    assign w_dlp_xfer  = dlp_vld && w_dlp_rdy;
    assign w_tlp_xfer  = tlp_vld && w_tlp_rdy;

`ifdef LPIF_ARB_STARVE_EN
    localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] r_starve_cnt;

    // Counts DLP packets sent while a TLP is left waiting; saturates at STARVE_MAX.
    always_ff @(posedge lclk or negedge lpreset_n) begin
        if (!lpreset_n) begin
            r_starve_cnt <= '0;
        end else if (!w_link_act || w_tlp_xfer) begin
            r_starve_cnt <= '0;
        end else if (w_dlp_xfer && w_dlp_final && tlp_vld &&
                     (r_starve_cnt != CNT_W'(STARVE_MAX))) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end

    assign w_starve_hit = (r_starve_cnt == CNT_W'(STARVE_MAX));
`else
    // STARVE_MAX has no effect when the counter is compiled out.
    assign w_starve_hit = 1'b0 & (STARVE_MAX != 0);
`endif

    always_ff @(posedge lclk or negedge lpreset_n) begin
        if (!lpreset_n) begin
            r_state    <= IDLE;
            r_link_act <= 1'b0;
            r_tx_abort <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_link_act <= w_link_act;
            r_tx_abort <= w_abort_nxt;
        end
    end

    // Next state and grants; the owning source keeps the port until its final beat.
    always_comb begin
        w_nxt_state = r_state;
        w_abort_nxt = 1'b0;
        w_dlp_rdy   = 1'b0;
        w_tlp_rdy   = 1'b0;
        if (!w_link_act) begin
            w_nxt_state = IDLE;
            w_abort_nxt = (r_state != IDLE);
        end else begin
            case (r_state)
                IDLE: begin
                    w_dlp_rdy = w_can_acc && !w_tlp_win;
                    w_tlp_rdy = w_can_acc && w_tlp_win;
                    if (w_dlp_rdy && dlp_vld && !w_dlp_final) begin
                        w_nxt_state = DLP_PKT;
                    end else if (w_tlp_rdy && tlp_vld && !w_tlp_final) begin
                        w_nxt_state = TLP_PKT;
                    end
                end
                DLP_PKT: begin
                    w_dlp_rdy = w_can_acc;
                    if (w_dlp_rdy && dlp_vld && w_dlp_final) begin
                        w_nxt_state = IDLE;
                    end
                end
                TLP_PKT: begin
                    w_tlp_rdy = w_can_acc;
                    if (w_tlp_rdy && tlp_vld && w_tlp_final) begin
                        w_nxt_state = IDLE;
                    end
                end
                default: w_nxt_state = IDLE;
            endcase
        end
    end

    assign dlp_rdy  = w_dlp_rdy;
    assign tlp_rdy  = w_tlp_rdy;
    assign tx_abort = r_tx_abort;

    lpif_tx_outreg #(
        .BYTES  (BYTES),
        .DATA_W (DATA_W)
    ) u_outreg (
        .lclk       (lclk),
        .lpreset_n  (lpreset_n),
        .i_flush    (!w_link_act),
        .i_load     (w_dlp_xfer || w_tlp_xfer),
        .i_is_tlp   (w_tlp_xfer),
        .i_data     (w_tlp_xfer ? tlp_data  : dlp_data),
        .i_valid    (w_tlp_xfer ? tlp_valid : dlp_valid),
        .i_start    (w_tlp_xfer ? tlp_start : dlp_start),
        .i_end      (w_tlp_xfer ? tlp_end   : dlp_end),
        .i_trdy     (pl_trdy),
        .o_irdy     (lp_irdy),
        .o_data     (lp_data),
        .o_valid    (lp_valid),
        .o_dlpstart (lp_dlpstart),
        .o_dlpend   (lp_dlpend),
        .o_tlpstart (lp_tlpstart),
        .o_tlpend   (lp_tlpend)
    );

endmodule

// File: tb/tb_lpif_tx_arbiter.sv
// Directed self-checking bench for lpif_tx_arbiter (default BYTES=64, STARVE_MAX=8).
`timescale 1ns/1ps
module tb_lpif_tx_arbiter;

    localparam int unsigned BYTES  = 64;
    localparam int unsigned DW     = 512;
    localparam int unsigned W      = 512;

    logic            lclk = 1'b0;
    logic            lpreset_n;
    logic [3:0]      pl_state_sts;
    logic            pl_linkUp;
    logic            dlp_vld, tlp_vld;
    logic            dlp_rdy, tlp_rdy;
    logic [DW-1:0]   dlp_data, tlp_data;
    logic [BYTES-1:0] dlp_valid, dlp_start, dlp_end;
    logic [BYTES-1:0] tlp_valid, tlp_start, tlp_end;
    logic            lp_irdy;
    logic [DW-1:0]   lp_data;
    logic [BYTES-1:0] lp_valid, lp_dlpstart, lp_dlpend, lp_tlpstart, lp_tlpend;
    logic            pl_trdy;
    logic            tx_abort;

    int errors = 0;
    int checks = 0;

    lpif_tx_arbiter dut (
        .lclk         (lclk),
        .lpreset_n    (lpreset_n),
        .pl_state_sts (pl_state_sts),
        .pl_linkUp    (pl_linkUp),
        .dlp_vld      (dlp_vld),
        .dlp_rdy      (dlp_rdy),
        .dlp_data     (dlp_data),
        .dlp_valid    (dlp_valid),
        .dlp_start    (dlp_start),
        .dlp_end      (dlp_end),
        .tlp_vld      (tlp_vld),
        .tlp_rdy      (tlp_rdy),
        .tlp_data     (tlp_data),
        .tlp_valid    (tlp_valid),
        .tlp_start    (tlp_start),
        .tlp_end      (tlp_end),
        .lp_irdy      (lp_irdy),
        .lp_data      (lp_data),
        .lp_valid     (lp_valid),
        .lp_dlpstart  (lp_dlpstart),
        .lp_dlpend    (lp_dlpend),
        .lp_tlpstart  (lp_tlpstart),
        .lp_tlpend    (lp_tlpend),
        .pl_trdy      (pl_trdy),
        .tx_abort     (tx_abort)
    );

    always #5 lclk = ~lclk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge lclk);
        #1;
    endtask

    task automatic drive_dlp(input logic vld, input logic [DW-1:0] d,
                             input logic [BYTES-1:0] s, input logic [BYTES-1:0] e);
        dlp_vld   = vld;
        dlp_data  = d;
        dlp_valid = '1;
        dlp_start = s;
        dlp_end   = e;
    endtask

    task automatic drive_tlp(input logic vld, input logic [DW-1:0] d,
                             input logic [BYTES-1:0] s, input logic [BYTES-1:0] e);
        tlp_vld   = vld;
        tlp_data  = d;
        tlp_valid = '1;
        tlp_start = s;
        tlp_end   = e;
    endtask

    logic [DW-1:0] d1, d2, d3, t1, ta, tb, tc;
    logic [BYTES-1:0] one;
    int n;

    initial begin
        one = BYTES'(1);
        d1 = {16{32'hD1D1_0001}};
        d2 = {16{32'hD2D2_0002}};
        d3 = {16{32'hD3D3_0003}};
        t1 = {16{32'hA1A1_0011}};
        ta = {16{32'hBAAA_0021}};
        tb = {16{32'hBBBB_0022}};
        tc = {16{32'hBCCC_0023}};

        lpreset_n    = 1'b0;
        pl_state_sts = 4'h1;
        pl_linkUp    = 1'b1;
        pl_trdy      = 1'b1;
        drive_dlp(1'b1, d1, one, one);
        drive_tlp(1'b1, t1, one, one);

        // Reset state, with both sources requesting
        tick();
        chk("rst_irdy",  W'(lp_irdy),  W'(0));
        chk("rst_data",  W'(lp_data),  W'(0));
        chk("rst_dlprdy", W'(dlp_rdy), W'(0));
        chk("rst_tlprdy", W'(tlp_rdy), W'(0));
        chk("rst_abort", W'(tx_abort), W'(0));
        chk("rst_dlpst", W'(lp_dlpstart), W'(0));
        drive_dlp(1'b0, '0, '0, '0);
        drive_tlp(1'b0, '0, '0, '0);
        lpreset_n = 1'b1;
        tick();

        // Single-beat DLP
        drive_dlp(1'b1, d1, one, one);
        #1 chk("sb_dlprdy", W'(dlp_rdy), W'(1));
        tick();
        drive_dlp(1'b0, '0, '0, '0);
        chk("sb_irdy",  W'(lp_irdy),     W'(1));
        chk("sb_data",  W'(lp_data),     W'(d1));
        chk("sb_dst",   W'(lp_dlpstart), W'(1));
        chk("sb_dend",  W'(lp_dlpend),   W'(1));
        chk("sb_tst",   W'(lp_tlpstart), W'(0));
        tick();
        chk("sb_drain", W'(lp_irdy),     W'(0));

        // DLP 2-beat and TLP requesting together: DLP first, no interleave
        drive_dlp(1'b1, d1, one, '0);
        drive_tlp(1'b1, t1, one, one);
        #1 chk("pri_dlprdy", W'(dlp_rdy), W'(1));
        chk("pri_tlprdy", W'(tlp_rdy), W'(0));
        tick();
        chk("pri_b1",    W'(lp_data),     W'(d1));
        chk("pri_b1end", W'(lp_dlpend),   W'(0));
        drive_dlp(1'b1, d2, '0, one);
        #1 chk("pri_lock", W'(tlp_rdy), W'(0));
        tick();
        chk("pri_b2",    W'(lp_data),     W'(d2));
        chk("pri_b2end", W'(lp_dlpend),   W'(1));
        drive_dlp(1'b0, '0, '0, '0);
        #1 chk("pri_tlpgo", W'(tlp_rdy), W'(1));
        tick();
        chk("pri_t1",    W'(lp_data),     W'(t1));
        chk("pri_tst",   W'(lp_tlpstart), W'(1));
        chk("pri_tdst",  W'(lp_dlpstart), W'(0));
        drive_tlp(1'b0, '0, '0, '0);
        tick();

        // 3-beat TLP with 4-cycle stall on beat 2
        drive_tlp(1'b1, ta, one, '0);
        tick();
        chk("stl_ta", W'(lp_data), W'(ta));
        drive_tlp(1'b1, tb, '0, '0);
        #1 chk("stl_tbrdy", W'(tlp_rdy), W'(1));
        tick();
        pl_trdy = 1'b0;
        drive_tlp(1'b1, tc, '0, one);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stl_rdy0", W'(tlp_rdy), W'(0));
            chk("stl_hold", W'(lp_data), W'(tb));
            chk("stl_irdy", W'(lp_irdy), W'(1));
            tick();
        end
        pl_trdy = 1'b1;
        #1 chk("stl_tcrdy", W'(tlp_rdy), W'(1));
        tick();
        chk("stl_tc",   W'(lp_data),   W'(tc));
        chk("stl_tend", W'(lp_tlpend), W'(1));
        drive_tlp(1'b0, '0, '0, '0);
        tick();
        chk("stl_drain", W'(lp_irdy), W'(0));

        // Continuous single-beat DLP with a TLP waiting
        drive_dlp(1'b1, d3, one, one);
        drive_tlp(1'b1, t1, one, one);
        #1;
        n = 0;
        while (n < 12 && !tlp_rdy) begin
            tick();
            n++;
        end
`ifdef LPIF_ARB_STARVE_EN
        chk("stv_count", W'(n), W'(8));
        tick();
        chk("stv_tst",  W'(lp_tlpstart), W'(1));
        chk("stv_data", W'(lp_data),     W'(t1));
`else
        chk("stv_count", W'(n),       W'(12));
        chk("stv_dlp",   W'(dlp_rdy), W'(1));
        chk("stv_tlp",   W'(tlp_rdy), W'(0));
`endif
        drive_dlp(1'b0, '0, '0, '0);
        drive_tlp(1'b0, '0, '0, '0);
        tick();
        tick();

        // Link drops mid-TLP
        drive_tlp(1'b1, ta, one, '0);
        tick();
        drive_tlp(1'b1, tb, '0, '0);
        pl_state_sts = 4'h0;
        #1 chk("ab_rdy0", W'(tlp_rdy), W'(0));
        tick();
        chk("ab_pulse", W'(tx_abort), W'(1));
        chk("ab_irdy",  W'(lp_irdy),  W'(0));
        chk("ab_data",  W'(lp_data),  W'(0));
        drive_tlp(1'b0, '0, '0, '0);
        tick();
        chk("ab_once",  W'(tx_abort), W'(0));
        pl_state_sts = 4'h1;
        tick();
        drive_dlp(1'b1, d2, one, one);
        #1 chk("ab_idle", W'(dlp_rdy), W'(1));
        tick();
        chk("ab_new",   W'(lp_data),     W'(d2));
        drive_dlp(1'b0, '0, '0, '0);
        tick();

        // Reset mid-packet
        drive_dlp(1'b1, d1, one, '0);
        tick();
        chk("rm_b1", W'(lp_irdy), W'(1));
        drive_dlp(1'b1, d2, '0, one);
        #2 lpreset_n = 1'b0;
        #1;
        chk("rm_irdy",  W'(lp_irdy),     W'(0));
        chk("rm_data",  W'(lp_data),     W'(0));
        chk("rm_dst",   W'(lp_dlpstart), W'(0));
        chk("rm_rdy",   W'(dlp_rdy),     W'(0));
        chk("rm_abort", W'(tx_abort),    W'(0));
        tick();
        lpreset_n = 1'b1;
        drive_dlp(1'b1, d3, one, one);
        tick();
        chk("rm_abort2", W'(tx_abort), W'(0));
        chk("rm_rdy1",   W'(dlp_rdy),  W'(1));
        tick();
        chk("rm_irdy1", W'(lp_irdy),     W'(1));
        chk("rm_new",   W'(lp_data),     W'(d3));
        chk("rm_nst",   W'(lp_dlpstart), W'(1));
        drive_dlp(1'b0, '0, '0, '0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
